// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grants bursts of up to BURST_LEN words and honours fifo_Full backpressure.
module fifo_wr_arbiter #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_REQ    = 4,
    parameter  int BURST_LEN  = 4,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_Full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic [15:0]                   wr_count
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [4:0]      burst_q, burst_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [IW-1:0]   pick;
    logic [IW-1:0]   gnt_inc;
    logic            any_v;
    logic            g_valid;
    logic            rdy_en;
    logic            xfer;
    logic            last;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        logic found;
        int   idx;
        pick  = rr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_q) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_v   = |req_valid;
    assign g_valid = req_valid[gnt_q];
    assign gnt_inc = (gnt_q == IW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
    assign last    = (burst_q == 5'(BURST_LEN - 1));

    assign rdy_en  = (state_q == GRANT) && !fifo_Full && !wr_rst;
    assign xfer    = rdy_en && g_valid;

    assign req_ready = rdy_en ? (NUM_REQ'(1) << gnt_q) : '0;
    assign wr_en     = xfer;
    assign wr_data   = xfer ? req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign busy      = (state_q == GRANT);
    assign grant_id  = gnt_q;
    assign wr_count  = cnt_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_v) begin
                    gnt_d   = pick;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    burst_d = burst_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        rr_d    = gnt_inc;
                    end
                end else if (!g_valid && !fifo_Full) begin
                    // Requester went idle; only release once backpressure is gone.
                    state_d = IDLE;
                    rr_d    = gnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
